// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//
// Purpose: lets the instruction-fetch requester and the load/store requester
// share one single-ported, pipelined memory. Load/store wins a conflict unless
// the fetch has already lost STARVE_MAX consecutive cycles. At most one access
// is issued per cycle. An owner pipeline, MEM_LAT entries deep, routes each
// read response back to the requester that issued the read.
//
// Parameters:
//   MEM_LAT     memory read latency in cycles, legal 1..4
//   STARVE_MAX  consecutive lost cycles before a fetch is forced through, 1..15
//
// Ports:
//   clk, x_reset                 clock and synchronous active-high reset
//   if_req/if_addr               fetch request and byte address
//   if_gnt                       fetch accepted this cycle
//   if_rvalid/if_rdata           fetch response (data is zero when not valid)
//   ls_req/ls_we/ls_addr         load/store request, 1 = store
//   ls_wdata/ls_be               store data and byte enables
//   ls_gnt                       load/store accepted this cycle
//   ls_rvalid/ls_rdata           load response (never pulses for stores)
//   mem_en/mem_we/mem_addr       memory access issued this cycle
//   mem_wdata/mem_be             memory write data and byte enables
//   mem_rdata                    memory read data, MEM_LAT cycles after issue
module riscv_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        x_reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

    logic [3:0]         starve_cnt;
    logic               force_if;
    logic               read_issue;
    owner_e             issue_owner;
    logic [MEM_LAT-1:0] pipe_valid;
    owner_e             pipe_owner [MEM_LAT];
    logic               tail_valid;

    // Arbitration. A fetch that has lost STARVE_MAX cycles in a row overrides
    // the load/store default priority. Reset suppresses every grant.
    always_comb begin
        force_if = (starve_cnt == STARVE_LIM);
        if_gnt   = 1'b0;
        ls_gnt   = 1'b0;
        if (!x_reset) begin
            if (if_req && (!ls_req || force_if)) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    // Memory port mux. Fetches are always reads; write data and byte enables
    // are only passed through for stores so reads present a clean zero.
    always_comb begin
        mem_en    = if_gnt | ls_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        if (ls_gnt) begin
            mem_we   = ls_we;
            mem_addr = ls_addr;
            if (ls_we) begin
                mem_wdata = ls_wdata;
                mem_be    = ls_be;
            end
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
        read_issue  = mem_en & ~mem_we;
        issue_owner = ls_gnt ? OWNER_LS : OWNER_IF;
    end

    // Counts consecutive cycles a pending fetch was refused. Any cycle where
    // the fetch is granted or not requesting starts the count over.
    always_ff @(posedge clk) begin
        if (x_reset) begin
            starve_cnt <= '0;
        end else if (if_req && !if_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Owner pipeline: entry 0 captures the read issued this cycle, and the
    // tail entry lines up with mem_rdata MEM_LAT cycles later. Writes and idle
    // cycles push an invalid entry so the shift is unconditional.
    always_ff @(posedge clk) begin
        if (x_reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_owner[i] <= OWNER_IF;
            end
        end else begin
            pipe_valid[0] <= read_issue;
            pipe_owner[0] <= issue_owner;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    // Response steering. Gating with x_reset drops a response that would
    // otherwise land in the reset cycle itself.
    always_comb begin
        tail_valid = pipe_valid[MEM_LAT-1] & ~x_reset;
        if_rvalid  = tail_valid && (pipe_owner[MEM_LAT-1] == OWNER_IF);
        ls_rvalid  = tail_valid && (pipe_owner[MEM_LAT-1] == OWNER_LS);
        if_rdata   = if_rvalid ? mem_rdata : '0;
        ls_rdata   = ls_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
//
// Purpose: self-checking bench for riscv_mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
// A behavioural model tracks how long the fetch has been waiting and keeps a
// queue of expected responses tagged with the cycle they are due. The bench
// also plays the memory: it returns memData(addr) for every read it saw issue.
module tb_riscv_mem_arbiter;

    localparam int LAT = 2;
    localparam int SM  = 4;

    logic        clk = 1'b0;
    logic        x_reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    riscv_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .x_reset   (x_reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        is_ls;
        logic [31:0] data;
    } resp_t;

    resp_t       pend_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          if_wait = 0;
    logic        hist_rd   [0:4095];
    logic [31:0] hist_addr [0:4095];

    logic        obs_if_gnt, obs_ls_gnt, obs_mem_we, obs_if_rvalid, obs_ls_rvalid;
    logic [31:0] obs_mem_addr, obs_if_rdata, obs_ls_rdata;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, checks every output at the falling edge
    // against the model, then advances the model across the rising edge.
    task automatic applyStimulus(input logic rst, input logic ifr, input logic [31:0] ifa,
                                 input logic lsr, input logic lswe, input logic [31:0] lsa,
                                 input logic [31:0] lswd, input logic [3:0] lsbe);
        logic        e_if, e_ls, e_en, e_we, e_irv, e_lrv;
        logic [31:0] e_addr, e_wdata, e_ird, e_lrd;
        logic [3:0]  e_be;
        resp_t       r;

        x_reset  = rst;
        if_req   = ifr;
        if_addr  = ifa;
        ls_req   = lsr;
        ls_we    = lswe;
        ls_addr  = lsa;
        ls_wdata = lswd;
        ls_be    = lsbe;
        if (cyc >= LAT && hist_rd[cyc-LAT]) mem_rdata = memData(hist_addr[cyc-LAT]);
        else                                mem_rdata = 32'hDEAD_BEEF;

        @(negedge clk);

        e_if = 1'b0;
        e_ls = 1'b0;
        if (!rst) begin
            if (ifr && lsr)  begin
                if (if_wait >= SM) e_if = 1'b1;
                else               e_ls = 1'b1;
            end else begin
                e_if = ifr;
                e_ls = lsr;
            end
        end
        e_en    = e_if | e_ls;
        e_we    = e_ls & lswe;
        e_addr  = e_if ? ifa : (e_ls ? lsa : 32'h0);
        e_be    = e_we ? lsbe : 4'b0000;
        e_wdata = e_we ? lswd : 32'h0;

        e_irv = 1'b0; e_lrv = 1'b0; e_ird = '0; e_lrd = '0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            r = pend_q.pop_front();
            if (!rst) begin
                if (r.is_ls) begin e_lrv = 1'b1; e_lrd = r.data; end
                else         begin e_irv = 1'b1; e_ird = r.data; end
            end
        end

        checkOutput("if_gnt",    if_gnt,    e_if);
        checkOutput("ls_gnt",    ls_gnt,    e_ls);
        checkOutput("mem_en",    mem_en,    e_en);
        checkOutput("mem_we",    mem_we,    e_we);
        checkOutput("mem_addr",  mem_addr,  e_addr);
        checkOutput("mem_be",    mem_be,    e_be);
        if (e_we || !e_en) checkOutput("mem_wdata", mem_wdata, e_wdata);
        checkOutput("if_rvalid", if_rvalid, e_irv);
        checkOutput("if_rdata",  if_rdata,  e_ird);
        checkOutput("ls_rvalid", ls_rvalid, e_lrv);
        checkOutput("ls_rdata",  ls_rdata,  e_lrd);

        obs_if_gnt    = if_gnt;
        obs_ls_gnt    = ls_gnt;
        obs_mem_we    = mem_we;
        obs_mem_addr  = mem_addr;
        obs_if_rvalid = if_rvalid;
        obs_if_rdata  = if_rdata;
        obs_ls_rvalid = ls_rvalid;
        obs_ls_rdata  = ls_rdata;
        hist_rd[cyc]   = mem_en & ~mem_we;
        hist_addr[cyc] = mem_addr;

        if (rst) begin
            if_wait = 0;
            pend_q.delete();
        end else begin
            if (ifr && !e_if) if_wait = (if_wait < SM) ? if_wait + 1 : SM;
            else              if_wait = 0;
            if (e_if)          pend_q.push_back('{cyc + LAT, 1'b0, memData(ifa)});
            if (e_ls && !lswe) pend_q.push_back('{cyc + LAT, 1'b1, memData(lsa)});
        end

        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        if_pend, ls_pend, r_we, rst_r;
        logic [31:0] r_ifa, r_lsa, r_wd, a_if, a_ls;
        logic [3:0]  r_be;

        x_reset = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0; ls_be = '0; mem_rdata = '0;
        @(posedge clk);
        #1;

        // Reset with requests asserted: every output must stay zero.
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        checkOutput("rst_if_gnt", obs_if_gnt, 1'b0);
        checkOutput("rst_mem_addr", obs_mem_addr, 32'h0);
        idle(1);

        // Single fetch, response LAT cycles later.
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("fetch_gnt", obs_if_gnt, 1'b1);
        checkOutput("fetch_addr", obs_mem_addr, 32'h100);
        idle(LAT - 1);
        checkOutput("fetch_early_rvalid", obs_if_rvalid, 1'b0);
        idle(1);
        checkOutput("fetch_rvalid", obs_if_rvalid, 1'b1);
        checkOutput("fetch_rdata", obs_if_rdata, memData(32'h100));
        checkOutput("fetch_ls_rvalid", obs_ls_rvalid, 1'b0);

        // Store: write strobe in the grant cycle, never a response.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h2004, 32'h0000_AB00, 4'b0010);
        checkOutput("store_gnt", obs_ls_gnt, 1'b1);
        checkOutput("store_we", obs_mem_we, 1'b1);
        idle(LAT + 2);

        // Both requests held: loads win four cycles, then the fetch wins.
        a_if = 32'h1000;
        a_ls = 32'h3000;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b1, a_if, 1'b1, 1'b0, a_ls, '0, '0);
            checkOutput("starve_if_gnt", obs_if_gnt, (i % 5) == 4);
            checkOutput("starve_ls_gnt", obs_ls_gnt, (i % 5) != 4);
            if (obs_if_gnt) a_if = a_if + 32'd4;
            if (obs_ls_gnt) a_ls = a_ls + 32'd4;
        end
        idle(LAT + 1);

        // Alternating back-to-back reads, responses in issue order.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) applyStimulus(1'b0, 1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0, '0, '0, '0);
            else            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h700 + 32'(i * 4), '0, '0);
        end
        idle(LAT + 1);

        // Reset with two reads in flight: both responses are dropped.
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h400, '0, '0);
        applyStimulus(1'b1, 1'b1, 32'h404, 1'b1, 1'b0, 32'h408, '0, '0);
        checkOutput("midrst_if_rvalid", obs_if_rvalid, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("midrst_ls_rvalid", obs_ls_rvalid, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, '0, '0, '0);
        idle(LAT);
        checkOutput("postrst_rvalid", obs_if_rvalid, 1'b1);
        checkOutput("postrst_rdata", obs_if_rdata, memData(32'h600));

        // Quiet bus.
        idle(10);
        checkOutput("idle_mem_addr", obs_mem_addr, 32'h0);

        // Randomised traffic with held requests, early drops and resets.
        if_pend = 1'b0; ls_pend = 1'b0;
        r_ifa = '0; r_lsa = '0; r_wd = '0; r_be = '0; r_we = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst_r = ($urandom_range(0, 99) == 0);
            if (!if_pend && $urandom_range(0, 2) != 0) begin
                if_pend = 1'b1;
                r_ifa   = $urandom & ~32'h3;
            end else if (if_pend && $urandom_range(0, 19) == 0) begin
                if_pend = 1'b0;
            end
            if (!ls_pend && $urandom_range(0, 2) != 0) begin
                ls_pend = 1'b1;
                r_we    = $urandom_range(0, 1) == 1;
                r_lsa   = $urandom;
                r_wd    = $urandom;
                r_be    = 4'($urandom_range(0, 15));
            end
            applyStimulus(rst_r, if_pend, r_ifa, ls_pend, r_we, r_lsa, r_wd, r_be);
            if (obs_if_gnt) if_pend = 1'b0;
            if (obs_ls_gnt) ls_pend = 1'b0;
        end
        idle(LAT + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
